// File: rtl/ifu_pkg.sv
// Shared encodings, reset defaults and fetch-address checking for the IFU.
package ifu_pkg;

    typedef enum logic [1:0] {
        NpcSeq    = 2'b00,
        NpcBranch = 2'b01,
        NpcJump   = 2'b10,
        NpcJr     = 2'b11
    } npc_sel_e;

    localparam logic [31:0] DefaultResetPc = 32'h0000_3000;
    localparam logic [31:0] NopInstr       = 32'h0000_0000;

    // Word-aligned and inside [base, base+size); the offset subtract wraps, so check base first.
    function automatic logic fetch_addr_ok(input logic [31:0] addr, input logic [31:0] base,
                                           input logic [31:0] size);
        logic [31:0] offset;
        offset = addr - base;
        return (addr[1:0] == 2'b00) && (addr >= base) && (offset < size);
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection; redirects are only honoured for a valid ID instruction.
module npc_calc
    import ifu_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] id_pc_i,
    input  logic        id_valid_i,
    input  logic [1:0]  npc_sel_i,
    input  logic        br_taken_i,
    input  logic [15:0] br_imm16_i,
    input  logic [25:0] j_imm26_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] npc_o,
    output logic        redirect_o
);

    logic [31:0] seq_pc;
    logic [31:0] br_target;
    logic [31:0] j_target;

    always_comb begin
        seq_pc    = pc_i + 32'd4;
        br_target = id_pc_i + 32'd4 + {{14{br_imm16_i[15]}}, br_imm16_i, 2'b00};
        j_target  = {id_pc_i[31:28], j_imm26_i, 2'b00};
        npc_o      = seq_pc;
        redirect_o = 1'b0;
        if (id_valid_i) begin
            unique case (npc_sel_e'(npc_sel_i))
                NpcSeq: ;
                NpcBranch: begin
                    if (br_taken_i) begin
                        npc_o      = br_target;
                        redirect_o = 1'b1;
                    end
                end
                NpcJump: begin
                    npc_o      = j_target;
                    redirect_o = 1'b1;
                end
                NpcJr: begin
                    npc_o      = jr_addr_i;
                    redirect_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register.
// Define IFU_DELAY_SLOT_EN to keep the delay-slot instruction instead of flushing it.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc,
    parameter int unsigned IM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic [1:0]  npc_sel_i,
    input  logic        br_taken_i,
    input  logic [15:0] br_imm16_i,
    input  logic [25:0] j_imm26_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc8_o,
    output logic        id_valid_o,
    output logic        exc_adel_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc8_q, id_pc8_d;
    logic        id_valid_q, id_valid_d;
    logic        exc_adel_q, exc_adel_d;

    logic [31:0] npc;
    logic        redirect;
    logic        flush;
    logic        fetch_ok;

    npc_calc u_npc_calc (
        .pc_i       (pc_q),
        .id_pc_i    (id_pc_q),
        .id_valid_i (id_valid_q),
        .npc_sel_i  (npc_sel_i),
        .br_taken_i (br_taken_i),
        .br_imm16_i (br_imm16_i),
        .j_imm26_i  (j_imm26_i),
        .jr_addr_i  (jr_addr_i),
        .npc_o      (npc),
        .redirect_o (redirect)
    );

`ifdef IFU_DELAY_SLOT_EN
    logic unused_redirect;
    assign unused_redirect = redirect;
    assign flush = 1'b0;
`else
    assign flush = redirect;
`endif

    assign fetch_ok = fetch_addr_ok(pc_q, RESET_PC, 32'(IM_BYTES));

    always_comb begin
        pc_d       = pc_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_pc8_d   = id_pc8_q;
        id_valid_d = id_valid_q;
        exc_adel_d = exc_adel_q;
        if (!stall_i) begin
            pc_d     = npc;
            id_pc_d  = pc_q;
            id_pc8_d = pc_q + 32'd8;
            if (!fetch_ok) begin
                id_instr_d = NopInstr;
                id_valid_d = 1'b0;
                exc_adel_d = 1'b1;
            end else if (flush) begin
                id_instr_d = NopInstr;
                id_valid_d = 1'b0;
                exc_adel_d = 1'b0;
            end else begin
                id_instr_d = instr_i;
                id_valid_d = 1'b1;
                exc_adel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            id_instr_q <= NopInstr;
            id_pc_q    <= 32'h0;
            id_pc8_q   <= 32'h0;
            id_valid_q <= 1'b0;
            exc_adel_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_pc8_q   <= id_pc8_d;
            id_valid_q <= id_valid_d;
            exc_adel_q <= exc_adel_d;
        end
    end

    assign pc_o       = pc_q;
    assign id_instr_o = id_instr_q;
    assign id_pc_o    = id_pc_q;
    assign id_pc8_o   = id_pc8_q;
    assign id_valid_o = id_valid_q;
    assign exc_adel_o = exc_adel_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: vector table plus reset-pulse, stall and misaligned-jr sequences.
module tb_ifu_fetch;

`ifdef IFU_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic [1:0]  npc_sel_i;
    logic        br_taken_i;
    logic [15:0] br_imm16_i;
    logic [25:0] j_imm26_i;
    logic [31:0] jr_addr_i;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc8_o;
    logic        id_valid_o;
    logic        exc_adel_o;

    int n_checks = 0;
    int n_fail   = 0;

    ifu_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_i    (stall_i),
        .npc_sel_i  (npc_sel_i),
        .br_taken_i (br_taken_i),
        .br_imm16_i (br_imm16_i),
        .j_imm26_i  (j_imm26_i),
        .jr_addr_i  (jr_addr_i),
        .pc_o       (pc_o),
        .instr_i    (instr_i),
        .id_instr_o (id_instr_o),
        .id_pc_o    (id_pc_o),
        .id_pc8_o   (id_pc8_o),
        .id_valid_o (id_valid_o),
        .exc_adel_o (exc_adel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: each word tags its own address.
    function automatic logic [31:0] w(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign instr_i = w(pc_o);

    typedef struct {
        logic [1:0]  sel;
        logic        taken;
        logic [15:0] imm16;
        logic [25:0] imm26;
        logic [31:0] jr;
        logic [31:0] e_pc;
        logic [31:0] e_id_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_adel;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] sel, input logic taken, input logic [15:0] i16,
                                input logic [25:0] i26, input logic [31:0] jr,
                                input logic [31:0] pc, input logic [31:0] idpc,
                                input logic [31:0] ins, input logic v, input logic ad);
        vec_t r;
        r.sel = sel; r.taken = taken; r.imm16 = i16; r.imm26 = i26; r.jr = jr;
        r.e_pc = pc; r.e_id_pc = idpc; r.e_instr = ins; r.e_valid = v; r.e_adel = ad;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] idpc,
                             input logic [31:0] pc8, input logic [31:0] ins, input logic v,
                             input logic ad);
        chk({tag, " pc_o"}, pc_o, pc);
        chk({tag, " id_pc_o"}, id_pc_o, idpc);
        chk({tag, " id_pc8_o"}, id_pc8_o, pc8);
        chk({tag, " id_instr_o"}, id_instr_o, ins);
        chk({tag, " id_valid_o"}, {31'b0, id_valid_o}, {31'b0, v});
        chk({tag, " exc_adel_o"}, {31'b0, exc_adel_o}, {31'b0, ad});
    endtask

    task automatic drive(input logic st, input logic [1:0] sel, input logic tk,
                         input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] jr);
        stall_i = st; npc_sel_i = sel; br_taken_i = tk;
        br_imm16_i = i16; j_imm26_i = i26; jr_addr_i = jr;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = mk(2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 32'h3000, w(32'h3000), 1, 0);
        vecs[1]  = mk(2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 32'h3004, w(32'h3004), 1, 0);
        vecs[2]  = mk(2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h300C, 32'h3008, w(32'h3008), 1, 0);
        vecs[3]  = mk(2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3010, 32'h300C, w(32'h300C), 1, 0);
        vecs[4]  = mk(2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3014, 32'h3010, w(32'h3010), 1, 0);
        vecs[5]  = mk(2'b01, 1, 16'hFFFC, 26'h0, 32'h0, 32'h3004, 32'h3014,
                      DS ? w(32'h3014) : 32'h0, DS, 0);
        vecs[6]  = mk(2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 32'h3004, w(32'h3004), 1, 0);
        vecs[7]  = mk(2'b01, 0, 16'hFFFC, 26'h0, 32'h0, 32'h300C, 32'h3008, w(32'h3008), 1, 0);
        vecs[8]  = mk(2'b10, 0, 16'h0, 26'h0000C10, 32'h0, 32'h3040, 32'h300C,
                      DS ? w(32'h300C) : 32'h0, DS, 0);
        vecs[9]  = mk(2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3044, 32'h3040, w(32'h3040), 1, 0);
        vecs[10] = mk(2'b11, 0, 16'h0, 26'h0, 32'h3100, 32'h3100, 32'h3044,
                      DS ? w(32'h3044) : 32'h0, DS, 0);
        vecs[11] = mk(2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3104, 32'h3100, w(32'h3100), 1, 0);
        vecs[12] = mk(2'b11, 0, 16'h0, 26'h0, 32'h4000, 32'h4000, 32'h3104,
                      DS ? w(32'h3104) : 32'h0, DS, 0);
        vecs[13] = mk(2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h4004, 32'h4000, 32'h0, 0, 1);
        // ID holds an invalid word, so this jump must be ignored.
        vecs[14] = mk(2'b10, 0, 16'h0, 26'h0000C10, 32'h0, 32'h4008, 32'h4004, 32'h0, 0, 1);

        rst_n = 1'b0;
        drive(0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 32'h3000, 32'h0, 32'h0, 32'h0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(0, vecs[i].sel, vecs[i].taken, vecs[i].imm16, vecs[i].imm26, vecs[i].jr);
            step();
            chk_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_id_pc,
                      vecs[i].e_id_pc + 32'd8, vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_adel);
        end

        // Mid-cycle reset pulse with a taken branch pending in ID.
        drive(0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        chk_state("rst_warm", 32'h3004, 32'h3000, 32'h3008, w(32'h3000), 1, 0);
        drive(0, 2'b01, 1, 16'hFFFC, 26'h0, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_state("rst_pulse", 32'h3000, 32'h0, 32'h0, 32'h0, 0, 0);
        #2;
        rst_n = 1'b1;
        step();
        chk_state("rst_after", 32'h3004, 32'h3000, 32'h3008, w(32'h3000), 1, 0);

        // Taken branch held off by a 3-cycle stall: target 3000+4+0x40.
        drive(1, 2'b01, 1, 16'h0010, 26'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state($sformatf("stall%0d", i), 32'h3004, 32'h3000, 32'h3008, w(32'h3000), 1, 0);
        end
        stall_i = 1'b0;
        step();
        chk_state("stall_rel", 32'h3044, 32'h3004, 32'h300C, DS ? w(32'h3004) : 32'h0, DS, 0);
        drive(0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
        step();
        chk_state("post_br", 32'h3048, 32'h3044, 32'h304C, w(32'h3044), 1, 0);

        // Misaligned jr target raises the address error one cycle later.
        drive(0, 2'b11, 0, 16'h0, 26'h0, 32'h3102);
        step();
        chk_state("jr_mis", 32'h3102, 32'h3048, 32'h3050, DS ? w(32'h3048) : 32'h0, DS, 0);
        drive(0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
        step();
        chk_state("adel_mis", 32'h3106, 32'h3102, 32'h310A, 32'h0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the first fetch address after reset.
REQ-002 Parameter IM_BYTES, default 4096, is the instruction-memory window size in bytes, starting at RESET_PC.
REQ-003 Port clk, input, 1 bit, is the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n, input, 1 bit, is the reset: asynchronous, active-low.
REQ-005 Port stall_i, input, 1 bit, SHALL hold the PC and the IF/ID register when 1.
REQ-006 Port npc_sel_i, input, 2 bits, selects next PC: 00 = pc+4, 01 = branch, 10 = jump imm26, 11 = jr.
REQ-007 Port br_taken_i, input, 1 bit, is the branch condition resolved in ID.
REQ-008 Port br_imm16_i, input, 16 bits, is the branch offset field of the ID instruction.
REQ-009 Port j_imm26_i, input, 26 bits, is the jump index field of the ID instruction.
REQ-010 Port jr_addr_i, input, 32 bits, is the forwarded rs value for jr.
REQ-011 Port pc_o, output, 32 bits, is the fetch address driven to instruction memory.
REQ-012 Port instr_i, input, 32 bits, is the combinational instruction word returned for pc_o.
REQ-013 Port id_instr_o, output, 32 bits, is the IF/ID instruction.
REQ-014 Port id_pc_o, output, 32 bits, is the IF/ID instruction address.
REQ-015 Port id_pc8_o, output, 32 bits, is id_pc_o+8, the link value.
REQ-016 Port id_valid_o, output, 1 bit, marks the IF/ID contents as a real instruction.
REQ-017 Port exc_adel_o, output, 1 bit, is the registered fetch address error for the ID instruction.

Function
REQ-018 The block SHALL hold a PC register; pc_o SHALL equal that register.
REQ-019 Branch target SHALL be id_pc_o+4+(sign_extend(br_imm16_i)<<2), computed mod 2^32.
REQ-020 Jump target SHALL be {id_pc_o[31:28], j_imm26_i, 2'b00}. jr target SHALL be jr_addr_i unmodified.
REQ-021 When stall_i=0, PC SHALL load the selected target. npc_sel_i=01 with br_taken_i=0 SHALL load pc+4.
REQ-022 npc_sel_i values other than 00 SHALL be honoured only while id_valid_o=1; otherwise PC SHALL load pc+4.
REQ-023 When stall_i=0, the IF/ID register SHALL capture instr_i, pc_o and pc_o+8, with latency 1 cycle from address to ID.
REQ-024 When stall_i=1, PC and IF/ID SHALL hold; a concurrent redirect SHALL be re-evaluated on the next unstalled cycle.
REQ-025 pc_o is misaligned when pc_o[1:0]!=0, and out of range when outside [RESET_PC, RESET_PC+IM_BYTES).
REQ-026 On a misaligned or out-of-range pc_o, the captured instruction SHALL be 32'h0, id_valid_o SHALL be 0, exc_adel_o SHALL be 1, and the PC SHALL still advance.
REQ-027 PC arithmetic SHALL wrap at 2^32 without a flag.

Reset
REQ-028 While rst_n=0: pc_o=RESET_PC, id_instr_o=0, id_pc_o=0, id_pc8_o=0, id_valid_o=0, exc_adel_o=0.
REQ-029 Reset asserted mid-operation SHALL discard any pending redirect. The first edge after release SHALL capture the word at RESET_PC.

Configuration
REQ-030 Macro IFU_DELAY_SLOT_EN defined: a taken redirect SHALL NOT flush IF/ID; the delay-slot instruction SHALL execute.
REQ-031 Macro undefined: a taken redirect with stall_i=0 SHALL load IF/ID with 32'h0 and id_valid_o=0 (one bubble). In this case id_pc8_o SHALL still be id_pc_o+8.

Structure
REQ-032 Package ifu_pkg SHALL hold the npc_sel encodings, the default RESET_PC, the NOP word (32'h0) and the address-check helper.
REQ-033 Next-PC selection SHALL be a combinational sub-module named npc_calc. ifu_fetch SHALL own all registers.

Verification
REQ-034 Reset release with sequential code -> pc_o = 3000, 3004, 3008; id_pc_o lags pc_o by 1 cycle; id_pc8_o = id_pc_o+8.
REQ-035 beq at 3010 with imm16=16'hFFFC and taken -> next pc_o = 3004.
- IFU_DELAY_SLOT_EN defined: 3014 enters ID with id_valid_o=1.
- Macro undefined: one bubble in ID.
REQ-036 j at 3000 with imm26=26'h0000C10 -> pc_o=3040. jr with jr_addr_i=3100 -> pc_o=3100.
REQ-037 stall_i=1 for 3 cycles during a taken branch -> pc_o and IF/ID frozen; redirect applied on the first unstalled edge.
REQ-038 jr_addr_i=3102 -> pc_o=3102; next cycle exc_adel_o=1, id_valid_o=0, id_instr_o=0. jr_addr_i=4000 (out of range) -> same response.
REQ-039 rst_n pulsed low for 3 ns between edges while a branch is pending -> pc_o=3000 immediately; branch never taken.
